// File: rtl/shifter_operand_decoder_if.sv
// Instruction/register-file/shifter bus of shifter_operand_decoder; the optional
// write-back bypass signals exist only when OPDEC_WB_BYPASS_EN is defined.
interface shifter_operand_decoder_if #(
  parameter int ADDR_WIDTH = 4
);
  logic                  in_flush;
  logic                  in_instr_valid;
  logic [31:0]           in_instr;
  logic                  out_instr_ready;
  logic [ADDR_WIDTH-1:0] out_rf_addr;
  logic [31:0]           in_rf_data;
  logic                  out_valid;
  logic                  in_ready;
  logic [31:0]           out_shift_data;
  logic [7:0]            out_shift_value;
  logic [2:0]            out_op_select;
  logic                  out_undef;
`ifdef OPDEC_WB_BYPASS_EN
  logic                  in_wb_en;
  logic [ADDR_WIDTH-1:0] in_wb_addr;
  logic [31:0]           in_wb_data;
`endif

  modport slave (
`ifdef OPDEC_WB_BYPASS_EN
    input  in_wb_en, in_wb_addr, in_wb_data,
`endif
    input  in_flush, in_instr_valid, in_instr, in_rf_data, in_ready,
    output out_instr_ready, out_rf_addr, out_valid, out_shift_data,
    output out_shift_value, out_op_select, out_undef
  );

  modport master (
`ifdef OPDEC_WB_BYPASS_EN
    output in_wb_en, in_wb_addr, in_wb_data,
`endif
    output in_flush, in_instr_valid, in_instr, in_rf_data, in_ready,
    input  out_instr_ready, out_rf_addr, out_valid, out_shift_data,
    input  out_shift_value, out_op_select, out_undef
  );
endinterface

// File: rtl/shifter_operand_decoder.sv
// Decodes ARM data-processing operand2 into barrel_shifter operands (data, amount, op).
// Define OPDEC_WB_BYPASS_EN to forward a same-cycle write-back into register-file reads.
module shifter_operand_decoder #(
  parameter int         ADDR_WIDTH      = 4,
  parameter logic [7:0] RRX_SHIFT_VALUE = 8'd1
) (
  input logic                 in_clk,
  input logic                 in_rst,
  shifter_operand_decoder_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RS   = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  localparam logic [2:0] OP_LSL = 3'b000;
  localparam logic [2:0] OP_ROR = 3'b011;
  localparam logic [2:0] OP_RRX = 3'b100;

  state_t                state_q, state_d;
  logic [31:0]           data_q, data_d;
  logic [7:0]            value_q, value_d;
  logic [2:0]            op_q, op_d;
  logic                  undef_q, undef_d;
  logic [ADDR_WIDTH-1:0] rs_q, rs_d;

  logic [ADDR_WIDTH-1:0] rf_addr;
  logic [31:0]           rf_data_eff;
  logic                  instr_ready;
  logic                  accept;

  logic [31:0]           dec_data;
  logic [7:0]            dec_value;
  logic [2:0]            dec_op;
  logic                  dec_undef;
  logic                  dec_regshift;
  logic [4:0]            imm5;
  logic [1:0]            sh_type;

  assign rf_addr = (state_q == S_RS) ? rs_q : bus.in_instr[ADDR_WIDTH-1:0];

`ifdef OPDEC_WB_BYPASS_EN
  assign rf_data_eff = (bus.in_wb_en && (bus.in_wb_addr == rf_addr)) ? bus.in_wb_data
                                                                     : bus.in_rf_data;
`else
  assign rf_data_eff = bus.in_rf_data;
`endif

  // Flush wins over everything so no instruction can slip in during the flush cycle.
  always_comb begin
    instr_ready = 1'b0;
    if (!bus.in_flush) begin
      case (state_q)
        S_IDLE:  instr_ready = 1'b1;
        S_OUT:   instr_ready = bus.in_ready;
        default: instr_ready = 1'b0;
      endcase
    end
  end

  assign accept = bus.in_instr_valid && instr_ready;

  assign imm5    = bus.in_instr[11:7];
  assign sh_type = bus.in_instr[6:5];

  always_comb begin
    dec_data     = '0;
    dec_value    = '0;
    dec_op       = OP_LSL;
    dec_undef    = 1'b0;
    dec_regshift = 1'b0;
    if (bus.in_instr[25]) begin
      dec_data  = {24'b0, bus.in_instr[7:0]};
      dec_value = {3'b0, bus.in_instr[11:8], 1'b0};
      dec_op    = OP_ROR;
    end else if (!bus.in_instr[4]) begin
      dec_data = rf_data_eff;
      dec_op   = {1'b0, sh_type};
      case (sh_type)
        2'b00: dec_value = {3'b0, imm5};
        2'b11: begin
          // ROR #0 is the RRX encoding.
          if (imm5 == 5'd0) begin
            dec_op    = OP_RRX;
            dec_value = RRX_SHIFT_VALUE;
          end else begin
            dec_value = {3'b0, imm5};
          end
        end
        default: dec_value = (imm5 == 5'd0) ? 8'd32 : {3'b0, imm5};
      endcase
    end else if (!bus.in_instr[7]) begin
      dec_data     = rf_data_eff;
      dec_op       = {1'b0, sh_type};
      dec_regshift = 1'b1;
    end else begin
      dec_undef = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    value_d = value_q;
    op_d    = op_q;
    undef_d = undef_q;
    rs_d    = rs_q;
    if (bus.in_flush) begin
      state_d = S_IDLE;
    end else if (accept) begin
      data_d  = dec_data;
      value_d = dec_value;
      op_d    = dec_op;
      undef_d = dec_undef;
      rs_d    = bus.in_instr[8 +: ADDR_WIDTH];
      state_d = dec_regshift ? S_RS : S_OUT;
    end else begin
      case (state_q)
        S_RS: begin
          value_d = rf_data_eff[7:0];
          state_d = S_OUT;
        end
        S_OUT: begin
          if (bus.in_ready) begin
            state_d = S_IDLE;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      value_q <= '0;
      op_q    <= OP_LSL;
      undef_q <= 1'b0;
      rs_q    <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      value_q <= value_d;
      op_q    <= op_d;
      undef_q <= undef_d;
      rs_q    <= rs_d;
    end
  end

  assign bus.out_instr_ready = instr_ready;
  assign bus.out_rf_addr     = rf_addr;
  assign bus.out_valid       = (state_q == S_OUT);
  assign bus.out_shift_data  = data_q;
  assign bus.out_shift_value = value_q;
  assign bus.out_op_select   = op_q;
  assign bus.out_undef       = undef_q;

endmodule

// File: tb/tb_shifter_operand_decoder.sv
// Bench for shifter_operand_decoder: directed vector table, corner sequences and a
// randomized scoreboard run against an operand2 reference model.
module tb_shifter_operand_decoder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  shifter_operand_decoder_if #(.ADDR_WIDTH(4)) bus ();

  shifter_operand_decoder #(
    .ADDR_WIDTH(4),
    .RRX_SHIFT_VALUE(8'd1)
  ) dut (
    .in_clk(clk),
    .in_rst(rst),
    .bus(bus)
  );

  logic [31:0] rf [16];
  always_comb bus.in_rf_data = rf[bus.out_rf_addr];

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [31:0] data;
    logic [7:0]  value;
    logic [2:0]  op;
    logic        undef;
  } exp_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] rf1;
    logic [31:0] data;
    logic [7:0]  value;
    logic [2:0]  op;
    logic        undef;
    int          lat;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Operand2 meaning, written from the ARM encoding rules with plain arithmetic.
  function automatic exp_t ref_model(input logic [31:0] ins);
    exp_t e;
    int   amt;
    int   kind;
    e = '0;
    amt  = int'(ins[11:7]);
    kind = int'(ins[6:5]);
    if (ins[25]) begin
      e.data  = 32'(ins[7:0]);
      e.value = 8'(int'(ins[11:8]) * 2);
      e.op    = 3'd3;
    end else if (ins[4] && ins[7]) begin
      e.undef = 1'b1;
    end else begin
      e.data = rf[ins[3:0]];
      e.op   = 3'(kind);
      if (ins[4]) begin
        e.value = 8'(rf[ins[11:8]] % 256);
      end else if (kind == 0) begin
        e.value = 8'(amt);
      end else if (kind == 3 && amt == 0) begin
        e.op    = 3'd4;
        e.value = 8'd1;
      end else if (kind == 3) begin
        e.value = 8'(amt);
      end else begin
        e.value = (amt == 0) ? 8'd32 : 8'(amt);
      end
    end
    return e;
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 3))
      0: r[25] = 1'b1;
      1: begin r[25] = 1'b0; r[4] = 1'b0; end
      2: begin r[25] = 1'b0; r[4] = 1'b1; r[7] = 1'b0; end
      default: begin r[25] = 1'b0; r[4] = 1'b1; r[7] = 1'b1; end
    endcase
    return r;
  endfunction

  task automatic run_vec(input vec_t v, input int idx);
    int cyc;
    rf[1] = v.rf1;
    @(negedge clk);
    bus.in_instr_valid = 1'b1;
    bus.in_instr       = v.instr;
    #1;
    chk($sformatf("v%0d ready_idle", idx), 64'(bus.out_instr_ready), 64'd1);
    chk($sformatf("v%0d rf_addr_rm", idx), 64'(bus.out_rf_addr), 64'(v.instr[3:0]));
    @(posedge clk);
    @(negedge clk);
    bus.in_instr_valid = 1'b0;
    cyc = 1;
    while (!bus.out_valid && cyc < 8) begin
      if (v.lat == 2) begin
        chk($sformatf("v%0d rf_addr_rs", idx), 64'(bus.out_rf_addr), 64'(v.instr[11:8]));
        chk($sformatf("v%0d ready_rs", idx), 64'(bus.out_instr_ready), 64'd0);
      end
      @(negedge clk);
      cyc++;
    end
    chk($sformatf("v%0d latency", idx), 64'(cyc), 64'(v.lat));
    chk($sformatf("v%0d data", idx), 64'(bus.out_shift_data), 64'(v.data));
    chk($sformatf("v%0d value", idx), 64'(bus.out_shift_value), 64'(v.value));
    chk($sformatf("v%0d op", idx), 64'(bus.out_op_select), 64'(v.op));
    chk($sformatf("v%0d undef", idx), 64'(bus.out_undef), 64'(v.undef));
    $display("vec %0d instr=%h data=%h value=%h op=%0d undef=%0d lat=%0d", idx, v.instr,
             bus.out_shift_data, bus.out_shift_value, bus.out_op_select, bus.out_undef, cyc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t        q [$];
    exp_t        got;
    exp_t        want;
    logic        hold;
    int          drain;

    vecs[0] = '{32'hE3A004FF, 32'h0,        32'h000000FF, 8'd8,    3'd3, 1'b0, 1};
    vecs[1] = '{32'hE1A00021, 32'h80000000, 32'h80000000, 8'd32,   3'd1, 1'b0, 1};
    vecs[2] = '{32'hE1A00061, 32'h12345678, 32'h12345678, 8'd1,    3'd4, 1'b0, 1};
    vecs[3] = '{32'hE1A00211, 32'h000000A5, 32'h000000A5, 8'h23,   3'd0, 1'b0, 2};
    vecs[4] = '{32'hE0000091, 32'h00000055, 32'h0,        8'd0,    3'd0, 1'b1, 1};
    vecs[5] = '{32'hE1A00041, 32'hF0000000, 32'hF0000000, 8'd32,   3'd2, 1'b0, 1};
    vecs[6] = '{32'hE1A00181, 32'h00000007, 32'h00000007, 8'd3,    3'd0, 1'b0, 1};
    vecs[7] = '{32'hE1A00271, 32'h000000A5, 32'h000000A5, 8'h23,   3'd3, 1'b0, 2};
    vecs[8] = '{32'hE3A00E12, 32'h0,        32'h00000012, 8'h1C,   3'd3, 1'b0, 1};

    for (int i = 0; i < 16; i++) rf[i] = 32'h0;
    rf[2] = 32'h00000123;
    bus.in_flush       = 1'b0;
    bus.in_instr_valid = 1'b0;
    bus.in_instr       = 32'h0;
    bus.in_ready       = 1'b1;
`ifdef OPDEC_WB_BYPASS_EN
    bus.in_wb_en   = 1'b0;
    bus.in_wb_addr = 4'd0;
    bus.in_wb_data = 32'h0;
`endif

    repeat (3) @(negedge clk);
    chk("reset out_valid", 64'(bus.out_valid), 64'd0);
    chk("reset data", 64'(bus.out_shift_data), 64'd0);
    chk("reset value", 64'(bus.out_shift_value), 64'd0);
    chk("reset op", 64'(bus.out_op_select), 64'd0);
    chk("reset undef", 64'(bus.out_undef), 64'd0);
    rst = 1'b0;
    #1;
    chk("idle ready", 64'(bus.out_instr_ready), 64'd1);
    $display("reset released");

    for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

    // Backpressure with a second instruction queued behind the stalled one.
    @(negedge clk);
    bus.in_ready       = 1'b0;
    bus.in_instr_valid = 1'b1;
    bus.in_instr       = 32'hE3A004FF;
    @(posedge clk);
    @(negedge clk);
    bus.in_instr = 32'hE3A00E12;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("bp out_valid", 64'(bus.out_valid), 64'd1);
      chk("bp data", 64'(bus.out_shift_data), 64'hFF);
      chk("bp value", 64'(bus.out_shift_value), 64'd8);
      chk("bp ready", 64'(bus.out_instr_ready), 64'd0);
      @(negedge clk);
    end
    bus.in_ready = 1'b1;
    #1;
    chk("bp release ready", 64'(bus.out_instr_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    bus.in_instr_valid = 1'b0;
    chk("b2b out_valid", 64'(bus.out_valid), 64'd1);
    chk("b2b data", 64'(bus.out_shift_data), 64'h12);
    chk("b2b value", 64'(bus.out_shift_value), 64'h1C);
    @(negedge clk);
    chk("bp single handoff", 64'(bus.out_valid), 64'd0);
    $display("backpressure sequence done");

    // Flush while waiting for Rs, with a competing valid instruction.
    rf[1] = 32'hA5;
    @(negedge clk);
    bus.in_instr_valid = 1'b1;
    bus.in_instr       = 32'hE1A00211;
    @(posedge clk);
    @(negedge clk);
    bus.in_instr = 32'hE3A004FF;
    bus.in_flush = 1'b1;
    #1;
    chk("flush ready", 64'(bus.out_instr_ready), 64'd0);
    @(posedge clk);
    @(negedge clk);
    bus.in_flush       = 1'b0;
    bus.in_instr_valid = 1'b0;
    chk("flush out_valid", 64'(bus.out_valid), 64'd0);
    #1;
    chk("flush idle ready", 64'(bus.out_instr_ready), 64'd1);
    @(negedge clk);
    chk("flush stays idle", 64'(bus.out_valid), 64'd0);
    $display("flush sequence done");

    // Asynchronous reset while holding a result.
    @(negedge clk);
    bus.in_ready       = 1'b0;
    bus.in_instr_valid = 1'b1;
    bus.in_instr       = 32'hE3A004FF;
    @(posedge clk);
    #2;
    bus.in_instr_valid = 1'b0;
    chk("pre-reset out_valid", 64'(bus.out_valid), 64'd1);
    rst = 1'b1;
    #1;
    chk("async rst out_valid", 64'(bus.out_valid), 64'd0);
    chk("async rst data", 64'(bus.out_shift_data), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.in_ready = 1'b1;
    $display("async reset sequence done");

`ifdef OPDEC_WB_BYPASS_EN
    rf[1] = 32'hA5;
    rf[2] = 32'h123;
    @(negedge clk);
    bus.in_instr_valid = 1'b1;
    bus.in_instr       = 32'hE1A00211;
    @(posedge clk);
    @(negedge clk);
    bus.in_instr_valid = 1'b0;
    bus.in_wb_en   = 1'b1;
    bus.in_wb_addr = 4'd2;
    bus.in_wb_data = 32'h4;
    @(posedge clk);
    @(negedge clk);
    bus.in_wb_en = 1'b0;
    chk("bypass out_valid", 64'(bus.out_valid), 64'd1);
    chk("bypass value", 64'(bus.out_shift_value), 64'h04);
    $display("bypass sequence value=%h", bus.out_shift_value);
`endif

    // Randomized traffic against the scoreboard.
    for (int i = 0; i < 16; i++) rf[i] = $urandom;
    hold = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (!hold) begin
        bus.in_instr_valid = ($urandom_range(0, 3) != 0);
        bus.in_instr       = gen_instr();
      end
      bus.in_ready = ($urandom_range(0, 2) != 0);
      #1;
      if (bus.in_instr_valid && bus.out_instr_ready) begin
        q.push_back(ref_model(bus.in_instr));
        hold = 1'b0;
      end else begin
        hold = bus.in_instr_valid;
      end
      if (bus.out_valid && bus.in_ready) begin
        got = {bus.out_shift_data, bus.out_shift_value, bus.out_op_select, bus.out_undef};
        if (q.size() == 0) begin
          chk("rand unexpected output", 64'd1, 64'd0);
        end else begin
          want = q.pop_front();
          chk("rand output", 64'(got), 64'(want));
          $display("rand handoff data=%h value=%h op=%0d undef=%0d", got.data, got.value,
                   got.op, got.undef);
        end
      end
    end
    @(negedge clk);
    bus.in_instr_valid = 1'b0;
    bus.in_ready       = 1'b1;
    drain = 0;
    while (q.size() != 0 && drain < 10) begin
      #1;
      if (bus.out_valid) begin
        got  = {bus.out_shift_data, bus.out_shift_value, bus.out_op_select, bus.out_undef};
        want = q.pop_front();
        chk("drain output", 64'(got), 64'(want));
      end
      @(negedge clk);
      drain++;
    end
    chk("scoreboard empty", 64'(q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
